uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Oversampling UART receiver (8N1, LSB first) feeding the echo datapath.
- Takes raw rs232_rx_i from the pin and synchronises it.
- Regenerates a sample tick from the system clock and majority-votes each bit.
- Delivers bytes through a single-entry valid/ready holding register with framing-error and overrun flags.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- SAMPLE_RATE, 16, ticks per bit (even, >=8).
- DIV is derived as CLK_FREQ/(BAUD*SAMPLE_RATE), truncated, and must be >=1. Default gives 78.

Ports:
- ice_clk_i  in  1  system clock; all logic on posedge.
- rstn_i  in  1  reset, asynchronous, active-low.
- rs232_rx_i  in  1  raw serial line, idle high.
- data_o  out  8  received byte.
- valid_o  out  1  data_o holds an unconsumed byte.
- ready_i  in  1  consumer accepts data_o when valid_o&&ready_i.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: good byte dropped because holding register full.

Behaviour:
- Reset (async, rstn_i=0):
  - Synchroniser flops =1, state IDLE, counters 0.
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0.
  - Reset mid-frame abandons the frame; nothing is output.
- Synchroniser: two flops; rx_s is rs232_rx_i delayed 2 clocks. All decisions use rx_s only.
- Tick generator:
  - Counter 0..DIV-1; tick on wrap.
  - Held at 0 in IDLE and WAIT_HIGH, so phase is aligned to start-edge detection.
- Sample counter: 0..SAMPLE_RATE-1, advanced per tick. MID=SAMPLE_RATE/2.
- Majority vote: samples taken at ticks MID-1, MID and MID+1. Bit = majority of the three.
- States:
  - IDLE: rx_s==0 → START; clear tick and sample counters.
  - START: at sample MID+1, voted 1 → IDLE (false start, no flags). At sample SAMPLE_RATE-1, voted 0 → DATA, bit index 0.
  - DATA: at sample MID+1, voted bit shifts into shift[7] (right shift, LSB first). At sample SAMPLE_RATE-1, bit index 7 → STOP, else index+1.
  - STOP: decided at sample MID+1, not at end of bit, so back-to-back frames are not missed.
    - Voted 1: deliver byte, → IDLE.
    - Voted 0: frame_err_o=1 for that cycle, byte discarded, → WAIT_HIGH.
  - WAIT_HIGH: rx_s==1 → IDLE. This prevents break/low line re-triggering.
- Holding register, evaluated on the delivery cycle:
  - valid_o=0: data_o<=byte, valid_o<=1.
  - valid_o=1 && ready_i=1 same cycle: old byte consumed, data_o<=new byte, valid_o stays 1, no overrun.
  - valid_o=1 && ready_i=0: new byte dropped, data_o unchanged, overrun_o=1 for one cycle.
- Consumption: valid_o&&ready_i with no delivery → valid_o<=0 next cycle. data_o holds its last value.
- Latency: valid_o rises on the clock after STOP sample MID+1 (+2 synchroniser cycles relative to the pin).
- Flags are mutually exclusive: frame_err_o and overrun_o are never high together.

Test Plan:
All cases use CLK_FREQ=640, BAUD=10, SAMPLE_RATE=16, so DIV=4 and one bit is 64 clocks.
- 0xA5 sent 8N1, ready_i=1 → exactly one valid_o cycle with data_o=0xA5, about 4+9.56*64 clocks after the start edge; flags stay 0.
- rx low for 8 clocks, then high → no valid_o, no frame_err_o; the next byte 0x0F is received correctly.
- 0x3C sent with stop bit 0, line then held low 200 clocks, then high → one frame_err_o pulse, valid_o stays 0, no further activity until high. A following 0x81 is received OK.
- 0x11 then 0x22 back-to-back, ready_i=0:
  - valid_o=1 with data_o=0x11.
  - overrun_o pulses once and data_o stays 0x11.
  - Then ready_i=1 for one cycle → valid_o=0.
- 0x55 with rx inverted for 4 clocks covering sample MID of bit 3 → majority corrects; data_o=0x55.
- rstn_i pulsed low during bit 4 of 0xFF → all outputs 0 immediately. The next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling 8N1 UART receiver with majority vote and valid/ready holding register
module uart_rx_os #(
    parameter int CLK_FREQ    = 12000000,
    parameter int BAUD        = 9600,
    parameter int SAMPLE_RATE = 16
) (
    input  logic       ice_clk_i,
    input  logic       rstn_i,
    input  logic       rs232_rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int DIV   = CLK_FREQ / (BAUD * SAMPLE_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SR_W  = $clog2(SAMPLE_RATE);
    localparam int MID   = SAMPLE_RATE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SR_W-1:0]  S_PRE    = SR_W'(MID - 1);
    localparam logic [SR_W-1:0]  S_MID    = SR_W'(MID);
    localparam logic [SR_W-1:0]  S_POST   = SR_W'(MID + 1);
    localparam logic [SR_W-1:0]  S_LAST   = SR_W'(SAMPLE_RATE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t            state_q, state_d;
    logic              rx_meta, rx_s;
    logic [DIV_W-1:0]  div_cnt;
    logic [SR_W-1:0]   smp_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_q;
    logic              vote_a, vote_b;
    logic              counting, tick, at_post, at_last, vote;
    logic              deliver, ferr;

    always_ff @(posedge ice_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rs232_rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Tick phase restarts from the start edge because the counters sit at 0 outside a frame
    assign counting = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign tick     = counting && (div_cnt == DIV_LAST);
    assign at_post  = tick && (smp_cnt == S_POST);
    assign at_last  = tick && (smp_cnt == S_LAST);
    assign vote     = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);

    always_ff @(posedge ice_clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        deliver = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE: if (!rx_s) state_d = START;
            START: begin
                if (at_post && vote) state_d = IDLE;
                else if (at_last)    state_d = DATA;
            end
            DATA: if (at_last && bit_idx == 3'd7) state_d = STOP;
            // Stop bit resolved mid-bit so a start edge right after it is still caught
            STOP: begin
                if (at_post) begin
                    if (vote) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ice_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            div_cnt <= '0;
            smp_cnt <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            vote_a  <= 1'b1;
            vote_b  <= 1'b1;
        end else if (!counting) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) smp_cnt <= (smp_cnt == S_LAST) ? '0 : smp_cnt + 1'b1;
            if (tick && smp_cnt == S_PRE) vote_a <= rx_s;
            if (tick && smp_cnt == S_MID) vote_b <= rx_s;
            if (state_q == DATA && at_post) shift_q <= {vote, shift_q[7:1]};
            if (state_q == START && at_last) bit_idx <= '0;
            if (state_q == DATA && at_last)  bit_idx <= bit_idx + 1'b1;
        end
    end

    always_ff @(posedge ice_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= ferr;
            overrun_o   <= deliver && valid_o && !ready_i;
            if (deliver) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shift_q;
                    valid_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - randomized scoreboard bench for uart_rx_os
module tb_uart_rx_os;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       rstn_i;
    logic       rs232_rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;

    int errors = 0;
    int checks = 0;
    int fe_seen = 0, fe_exp = 0;
    int ov_seen = 0, ov_exp = 0;
    int lat;
    logic [7:0] exp_q[$];

    uart_rx_os #(.CLK_FREQ(640), .BAUD(10), .SAMPLE_RATE(16)) dut (
        .ice_clk_i  (clk),
        .rstn_i     (rstn_i),
        .rs232_rx_i (rs232_rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rs232_rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_frame_err_count"}, fe_seen, fe_exp);
        chk({tag, "_overrun_count"}, ov_seen, ov_exp);
    endtask

    // glitch_bit: invert the line for 4 clocks around that bit's mid sample; rst_bit: reset inside that bit
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit, input int rst_bit);
        logic [9:0] bits;
        logic       inv;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                inv = (i == glitch_bit && c >= 34 && c <= 37) ? 1'b1 : 1'b0;
                rs232_rx_i = bits[i] ^ inv;
                if (i == rst_bit && c == 10) begin
                    rstn_i = 1'b0;
                    #1;
                    chk("rst_mid_data", data_o, 8'h00);
                    chk("rst_mid_valid", valid_o, 1'b0);
                    chk("rst_mid_frame_err", frame_err_o, 1'b0);
                    chk("rst_mid_overrun", overrun_o, 1'b0);
                    repeat (2) @(negedge clk);
                    rs232_rx_i = 1'b1;
                    rstn_i = 1'b1;
                    return;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rstn_i) begin
                if (valid_o && ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none", data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (data_o !== e) begin
                            errors++;
                            $display("FAIL rx_byte: got %02h expected %02h", data_o, e);
                        end
                    end
                end
                if (frame_err_o) fe_seen++;
                if (overrun_o) ov_seen++;
                if (frame_err_o || overrun_o) begin
                    checks++;
                    if (frame_err_o && overrun_o) begin
                        errors++;
                        $display("FAIL flags_exclusive: got both high expected one");
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        rstn_i = 1'b0;
        rs232_rx_i = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_data", data_o, 8'h00);
        chk("reset_valid", valid_o, 1'b0);
        chk("reset_frame_err", frame_err_o, 1'b0);
        chk("reset_overrun", overrun_o, 1'b0);
        @(negedge clk);
        rstn_i = 1'b1;
        idle(10);

        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, -1, -1);
            begin
                lat = 0;
                while (valid_o !== 1'b1 && lat < 800) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        checks++;
        if (lat < 616 || lat > 622) begin
            errors++;
            $display("FAIL a5_latency: got %0d clocks expected 616..622", lat);
        end
        idle(20);
        check_flags("a5");

        rs232_rx_i = 1'b0;
        repeat (8) @(negedge clk);
        idle(100);
        check_flags("false_start");
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, -1, -1);
        idle(20);

        send_frame(8'h3C, 1'b0, -1, -1);
        fe_exp++;
        rs232_rx_i = 1'b0;
        repeat (200) @(negedge clk);
        check_flags("stop_low");
        idle(40);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, -1);
        idle(20);
        check_flags("after_break");

        ready_i = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        ov_exp++;
        idle(20);
        chk("overrun_hold_valid", valid_o, 1'b1);
        chk("overrun_hold_data", data_o, 8'h11);
        check_flags("overrun");
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        #1;
        chk("consume_valid_low", valid_o, 1'b0);
        @(negedge clk);
        ready_i = 1'b1;
        idle(10);

        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 3, -1);
        idle(20);

        ready_i = 1'b0;
        send_frame(8'h77, 1'b1, -1, -1);
        idle(10);
        chk("pre_reset_valid", valid_o, 1'b1);
        chk("pre_reset_data", data_o, 8'h77);
        send_frame(8'hFF, 1'b1, -1, 4);
        ready_i = 1'b1;
        idle(30);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, -1, -1);
        idle(20);

        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, -1, -1);
            idle($urandom_range(0, 40));
        end
        idle(100);
        chk("queue_drained", exp_q.size(), 0);
        check_flags("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
